engine_dispatch_n: RTL and testbench
====================================

# engine_dispatch_n

Parametrised ap_ctrl_chain dispatcher for NUM_ENG identical processing engines sharing one AXI read master and one AXI write master. It accepts kernel jobs, assigns them round-robin to engines, steers the read stream to the target engine, and serialises write-back in dispatch order. It queues multiple completions for ap_done/ap_continue. It sits between the kernel control block and the engine array.

## Interface
Parameters:
- NUM_ENG, 4, number of engines (1..8)
- DATA_W, 128, AXI-Stream data width
- ADDR_W, 64, write address/size width
- CNT_W, $clog2(NUM_ENG+1), width of the busy and pending counters (derived)

Ports:
- aclk  in  1  clock
- areset_n  in  1  asynchronous active-low reset
- s_rd_tvalid / s_rd_tdata / s_rd_tready  in/in/out  1/DATA_W/1  stream from read master
- eng_rd_tvalid / eng_rd_tdata / eng_rd_tready  out/out/in  NUM_ENG/NUM_ENG*DATA_W/NUM_ENG  per-engine input streams
- eng_wr_tvalid / eng_wr_tdata / eng_wr_tready  in/in/out  NUM_ENG/NUM_ENG*DATA_W/NUM_ENG  per-engine output streams
- m_wr_tvalid / m_wr_tdata / m_wr_tready  out/out/in  1/DATA_W/1  stream to write master
- rmst_req  out  1  read-master start pulse
- rmst_done  in  1  read transfer complete pulse
- wmst_req  out  1  write-master start pulse
- wmst_xfer_addr / wmst_xfer_size  out  ADDR_W each  selected engine's write descriptor
- wmst_done  in  1  write transfer complete pulse
- eng_wreq  in  NUM_ENG  per-engine write request pulse
- eng_waddr / eng_wsize  in  NUM_ENG*ADDR_W each  per-engine descriptors, slice i = bits [i*ADDR_W +: ADDR_W]
- ap_start, ap_continue  in  1 each  kernel control
- ap_ready, ap_done, ap_idle  out  1 each  kernel control
- op_start  out  NUM_ENG  per-engine start pulse

## Operation
- accept = ap_start & ap_ready.
- ap_ready = (busy_cnt < NUM_ENG) & !rmst_busy & !rmst_req.
- in_ptr: resets to 0. On rmst_done while rmst_busy, in_ptr = (in_ptr+1) mod NUM_ENG.
- rmst_busy: set on accept, cleared on qualified rmst_done. rmst_done while idle is ignored.
- rmst_req: 1-cycle pulse, registered from accept.
- op_start[in_ptr]: 1-cycle pulse, registered from accept.
- busy_cnt: +1 on accept, −1 on qualified wmst_done, unchanged if both occur in the same cycle.
- Read mux: eng_rd_tvalid[in_ptr] = s_rd_tvalid, eng_rd_tdata slice in_ptr = s_rd_tdata, s_rd_tready = eng_rd_tready[in_ptr]. Unselected tvalid and tdata drive 0.
- wreq_latch[i]: set on eng_wreq[i], cleared when wmst_req issues for out_ptr==i. Set has priority.
- wmst_req: 1-cycle pulse when latch[out_ptr] & !wmst_busy & !wmst_req.
- wmst_busy: set on wmst_req, cleared on wmst_done. wmst_done while idle is ignored.
- out_ptr: resets to 0, advances mod NUM_ENG on qualified wmst_done. This enforces in-order write-back; a later engine's latched request waits.
- Write mux by out_ptr:
  - m_wr_tvalid/m_wr_tdata come from engine out_ptr.
  - eng_wr_tready[out_ptr] = m_wr_tready; others 0.
  - wmst_xfer_addr/size come combinationally from slice out_ptr.
- pend_cnt: +1 on qualified wmst_done, −1 on ap_done & ap_continue, unchanged if both occur.
- ap_done = (pend_cnt != 0).
- ap_idle = (busy_cnt == 0) & (pend_cnt == 0).

## Timing
- Reset values: all pointers and counters 0; rmst_busy, wmst_busy, wreq_latch 0; rmst_req, wmst_req, op_start 0; ap_done 0, ap_idle 1, ap_ready 1; all stream outputs and descriptor outputs 0 except muxed pass-through of engine 0.
- accept at cycle T gives rmst_req=1 and op_start[k]=1 at T+1. ap_ready is low from T+1 until the cycle after rmst_done.
- eng_wreq at T sets latch at T+1; wmst_req fires at T+2 if the write master is free and out_ptr matches.
- Descriptor outputs must be stable from wmst_req until wmst_done. out_ptr changes only on wmst_done.
- Stream muxes are purely combinational, with zero latency.
- Reset mid-operation clears all state immediately; in-flight pulses are dropped.
- For NUM_ENG=1, pointers are constant 0.

## Test plan
- Single job, NUM_ENG=4: ap_start held → ap_ready deasserts at T+1, rmst_req and op_start=4'b0001 pulse at T+1; rmst_done → in_ptr=1, ap_ready=1.
- Five jobs with no wmst_done: jobs 0–3 accepted, ap_ready stays 0 after the fourth read completes (busy_cnt=4); one wmst_done → ap_ready=1, fifth job goes to engine 0.
- Out-of-order requests: eng_wreq[1] before eng_wreq[0] → no wmst_req until eng_wreq[0]; first wmst_req has engine 0's addr, second has engine 1's addr after wmst_done.
- Three wmst_done pulses with ap_continue low → ap_done=1, pend_cnt=3; three ap_continue cycles → ap_done falls after the third; ap_idle=1.
- Simultaneous accept and wmst_done → busy_cnt unchanged. Simultaneous wmst_done and ap_done&ap_continue → pend_cnt unchanged.
- areset_n low while wmst_busy → all outputs at reset values on the next edge; a subsequent job is dispatched to engine 0.

Source files
------------

// File: rtl/engine_dispatch_n.sv
// engine_dispatch_n: ap_ctrl_chain job dispatcher for NUM_ENG identical engines.
// Jobs are handed out round-robin, the read stream is steered to the engine
// being loaded, and write-back is serialised in the same order jobs went out.
// Completions are counted so several ap_done/ap_continue handshakes can queue.

// Per-engine slice: read-stream demux gating, write-ready gating and the
// sticky write-request latch for one engine.
module engine_dispatch_lane #(
    parameter int DATA_W = 128
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic              rd_sel,
    input  logic              wr_sel,
    input  logic              s_rd_tvalid,
    input  logic [DATA_W-1:0] s_rd_tdata,
    output logic              eng_rd_tvalid,
    output logic [DATA_W-1:0] eng_rd_tdata,
    input  logic              m_wr_tready,
    output logic              eng_wr_tready,
    input  logic              wreq,
    input  logic              wreq_clr,
    output logic              wreq_latch
);

    // Only the selected engine sees the read stream; others are held at zero.
    always_comb begin
        eng_rd_tvalid = rd_sel & s_rd_tvalid;
        eng_rd_tdata  = rd_sel ? s_rd_tdata : '0;
        eng_wr_tready = wr_sel & m_wr_tready;
    end

    // Write request is remembered until its turn comes; a new request wins
    // over a clear arriving in the same cycle.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n)     wreq_latch <= 1'b0;
        else if (wreq)     wreq_latch <= 1'b1;
        else if (wreq_clr) wreq_latch <= 1'b0;
    end

endmodule

module engine_dispatch_n #(
    parameter int NUM_ENG = 4,
    parameter int DATA_W  = 128,
    parameter int ADDR_W  = 64,
    parameter int CNT_W   = $clog2(NUM_ENG + 1)
) (
    input  logic                            aclk,
    input  logic                            areset_n,
    // read master stream in, per-engine streams out
    input  logic                            s_rd_tvalid,
    input  logic [DATA_W-1:0]               s_rd_tdata,
    output logic                            s_rd_tready,
    output logic [NUM_ENG-1:0]              eng_rd_tvalid,
    output logic [NUM_ENG-1:0][DATA_W-1:0]  eng_rd_tdata,
    input  logic [NUM_ENG-1:0]              eng_rd_tready,
    // per-engine result streams in, write master stream out
    input  logic [NUM_ENG-1:0]              eng_wr_tvalid,
    input  logic [NUM_ENG-1:0][DATA_W-1:0]  eng_wr_tdata,
    output logic [NUM_ENG-1:0]              eng_wr_tready,
    output logic                            m_wr_tvalid,
    output logic [DATA_W-1:0]               m_wr_tdata,
    input  logic                            m_wr_tready,
    // master handshakes
    output logic                            rmst_req,
    input  logic                            rmst_done,
    output logic                            wmst_req,
    output logic [ADDR_W-1:0]               wmst_xfer_addr,
    output logic [ADDR_W-1:0]               wmst_xfer_size,
    input  logic                            wmst_done,
    // per-engine write descriptors
    input  logic [NUM_ENG-1:0]              eng_wreq,
    input  logic [NUM_ENG-1:0][ADDR_W-1:0]  eng_waddr,
    input  logic [NUM_ENG-1:0][ADDR_W-1:0]  eng_wsize,
    // kernel control
    input  logic                            ap_start,
    input  logic                            ap_continue,
    output logic                            ap_ready,
    output logic                            ap_done,
    output logic                            ap_idle,
    output logic [NUM_ENG-1:0]              op_start
);

    localparam int PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    logic [PTR_W-1:0]   in_ptr, out_ptr;
    logic [CNT_W-1:0]   busy_cnt, pend_cnt;
    logic               rmst_busy, wmst_busy;
    logic               accept, rmst_done_q, wmst_done_q, ack, wreq_fire;
    logic [NUM_ENG-1:0] rd_sel, wr_sel, wreq_latch, wreq_clr;

    // Round-robin step; wraps at NUM_ENG so non-power-of-two counts work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NUM_ENG - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    // Handshake qualifiers and the write-issue decision.
    always_comb begin
        ap_ready    = (busy_cnt < CNT_W'(NUM_ENG)) & ~rmst_busy & ~rmst_req;
        accept      = ap_start & ap_ready;
        rmst_done_q = rmst_done & rmst_busy;
        wmst_done_q = wmst_done & wmst_busy;
        ap_done     = (pend_cnt != '0);
        ap_idle     = (busy_cnt == '0) & (pend_cnt == '0);
        ack         = ap_done & ap_continue;
        wreq_fire   = wreq_latch[out_ptr] & ~wmst_busy & ~wmst_req;
    end

    // Shared-side muxes: zero latency, selected purely by the pointers.
    always_comb begin
        s_rd_tready    = eng_rd_tready[in_ptr];
        m_wr_tvalid    = eng_wr_tvalid[out_ptr];
        m_wr_tdata     = eng_wr_tdata[out_ptr];
        wmst_xfer_addr = eng_waddr[out_ptr];
        wmst_xfer_size = eng_wsize[out_ptr];
    end

    genvar g;
    generate
        for (g = 0; g < NUM_ENG; g++) begin : g_lane
            assign rd_sel[g]   = (in_ptr == PTR_W'(g));
            assign wr_sel[g]   = (out_ptr == PTR_W'(g));
            assign wreq_clr[g] = wreq_fire & wr_sel[g];

            engine_dispatch_lane #(.DATA_W(DATA_W)) u_lane (
                .aclk          (aclk),
                .areset_n      (areset_n),
                .rd_sel        (rd_sel[g]),
                .wr_sel        (wr_sel[g]),
                .s_rd_tvalid   (s_rd_tvalid),
                .s_rd_tdata    (s_rd_tdata),
                .eng_rd_tvalid (eng_rd_tvalid[g]),
                .eng_rd_tdata  (eng_rd_tdata[g]),
                .m_wr_tready   (m_wr_tready),
                .eng_wr_tready (eng_wr_tready[g]),
                .wreq          (eng_wreq[g]),
                .wreq_clr      (wreq_clr[g]),
                .wreq_latch    (wreq_latch[g])
            );
        end
    endgenerate

    // Read side: start pulses, busy flag and the input pointer.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            rmst_req  <= 1'b0;
            op_start  <= '0;
            rmst_busy <= 1'b0;
            in_ptr    <= '0;
        end else begin
            rmst_req <= accept;
            op_start <= accept ? rd_sel : '0;
            if (accept)           rmst_busy <= 1'b1;
            else if (rmst_done_q) rmst_busy <= 1'b0;
            if (rmst_done_q)      in_ptr    <= ptr_inc(in_ptr);
        end
    end

    // Write side: one transfer in flight; out_ptr moves only on completion
    // so the descriptor mux stays stable for the whole transfer.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wmst_req  <= 1'b0;
            wmst_busy <= 1'b0;
            out_ptr   <= '0;
        end else begin
            wmst_req <= wreq_fire;
            if (wmst_req)         wmst_busy <= 1'b1;
            else if (wmst_done_q) wmst_busy <= 1'b0;
            if (wmst_done_q)      out_ptr   <= ptr_inc(out_ptr);
        end
    end

    // Job accounting: engines occupied, and completions awaiting ap_continue.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            busy_cnt <= '0;
            pend_cnt <= '0;
        end else begin
            case ({accept, wmst_done_q})
                2'b10:   busy_cnt <= busy_cnt + CNT_W'(1);
                2'b01:   busy_cnt <= busy_cnt - CNT_W'(1);
                default: busy_cnt <= busy_cnt;
            endcase
            case ({wmst_done_q, ack})
                2'b10:   pend_cnt <= pend_cnt + CNT_W'(1);
                2'b01:   pend_cnt <= pend_cnt - CNT_W'(1);
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_engine_dispatch_n.sv
// Directed bench for engine_dispatch_n with NUM_ENG=4.
module tb_engine_dispatch_n;

    localparam int NE = 4;
    localparam int DW = 128;
    localparam int AW = 64;

    logic              aclk = 1'b0;
    logic              areset_n;
    logic              s_rd_tvalid;
    logic [DW-1:0]     s_rd_tdata;
    logic              s_rd_tready;
    logic [NE-1:0]     eng_rd_tvalid;
    logic [NE*DW-1:0]  eng_rd_tdata;
    logic [NE-1:0]     eng_rd_tready;
    logic [NE-1:0]     eng_wr_tvalid;
    logic [NE*DW-1:0]  eng_wr_tdata;
    logic [NE-1:0]     eng_wr_tready;
    logic              m_wr_tvalid;
    logic [DW-1:0]     m_wr_tdata;
    logic              m_wr_tready;
    logic              rmst_req, rmst_done, wmst_req, wmst_done;
    logic [AW-1:0]     wmst_xfer_addr, wmst_xfer_size;
    logic [NE-1:0]     eng_wreq;
    logic [NE*AW-1:0]  eng_waddr, eng_wsize;
    logic              ap_start, ap_continue, ap_ready, ap_done, ap_idle;
    logic [NE-1:0]     op_start;

    int n_tests = 0;
    int n_fail  = 0;

    engine_dispatch_n #(.NUM_ENG(NE), .DATA_W(DW), .ADDR_W(AW)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .s_rd_tvalid(s_rd_tvalid), .s_rd_tdata(s_rd_tdata), .s_rd_tready(s_rd_tready),
        .eng_rd_tvalid(eng_rd_tvalid), .eng_rd_tdata(eng_rd_tdata), .eng_rd_tready(eng_rd_tready),
        .eng_wr_tvalid(eng_wr_tvalid), .eng_wr_tdata(eng_wr_tdata), .eng_wr_tready(eng_wr_tready),
        .m_wr_tvalid(m_wr_tvalid), .m_wr_tdata(m_wr_tdata), .m_wr_tready(m_wr_tready),
        .rmst_req(rmst_req), .rmst_done(rmst_done),
        .wmst_req(wmst_req), .wmst_xfer_addr(wmst_xfer_addr), .wmst_xfer_size(wmst_xfer_size),
        .wmst_done(wmst_done),
        .eng_wreq(eng_wreq), .eng_waddr(eng_waddr), .eng_wsize(eng_wsize),
        .ap_start(ap_start), .ap_continue(ap_continue),
        .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
        .op_start(op_start)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return 64'h1000 + 64'(i) * 64'h100;
    endfunction

    function automatic logic [AW-1:0] size_of(input int i);
        return 64'h40 + 64'(i);
    endfunction

    // Accept one job at the current in_ptr and complete its read.
    task automatic do_job(input int k, input string tag);
        ap_start = 1'b1;
        chk({tag, "_ready"}, 512'(ap_ready), 512'(1));
        tick();
        ap_start = 1'b0;
        chk({tag, "_op_start"}, 512'(op_start), 512'(4'b0001 << k));
        chk({tag, "_rmst_req"}, 512'(rmst_req), 512'(1));
        rmst_done = 1'b1;
        tick();
        rmst_done = 1'b0;
    endtask

    // Engine k requests write-back, transfer issues and completes.
    task automatic do_write(input int k, input string tag);
        eng_wreq = 4'b0001 << k;
        tick();
        eng_wreq = '0;
        tick();
        chk({tag, "_wmst_req"}, 512'(wmst_req), 512'(1));
        chk({tag, "_addr"}, 512'(wmst_xfer_addr), 512'(addr_of(k)));
        tick();
        wmst_done = 1'b1;
        tick();
        wmst_done = 1'b0;
    endtask

    initial begin
        areset_n = 1'b0;
        s_rd_tvalid = 0; s_rd_tdata = '0; eng_rd_tready = '0;
        eng_wr_tvalid = '0; eng_wr_tdata = '0; m_wr_tready = 0;
        rmst_done = 0; wmst_done = 0; eng_wreq = '0;
        ap_start = 0; ap_continue = 0;
        for (int i = 0; i < NE; i++) begin
            eng_waddr[i*AW +: AW] = addr_of(i);
            eng_wsize[i*AW +: AW] = size_of(i);
        end
        tick(); tick();
        areset_n = 1'b1;

        // reset state
        chk("rst_ready", 512'(ap_ready), 512'(1));
        chk("rst_idle",  512'(ap_idle),  512'(1));
        chk("rst_done",  512'(ap_done),  512'(0));
        chk("rst_pulses", 512'({rmst_req, wmst_req, op_start}), 512'(0));
        chk("rst_desc", 512'(wmst_xfer_addr), 512'(addr_of(0)));

        // read demux follows in_ptr=0
        s_rd_tvalid = 1'b1; s_rd_tdata = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
        eng_rd_tready = 4'b0001;
        #1;
        chk("rd_vld0", 512'(eng_rd_tvalid), 512'(4'b0001));
        chk("rd_dat0", 512'(eng_rd_tdata), {384'd0, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666});
        chk("rd_rdy0", 512'(s_rd_tready), 512'(1));
        eng_rd_tready = 4'b1110;
        #1;
        chk("rd_rdy0_n", 512'(s_rd_tready), 512'(0));
        s_rd_tvalid = 1'b0; s_rd_tdata = '0; eng_rd_tready = '0;

        // single job: pulses at T+1, ready back after rmst_done
        ap_start = 1'b1;
        tick();
        chk("j0_rmst_req", 512'(rmst_req), 512'(1));
        chk("j0_op_start", 512'(op_start), 512'(4'b0001));
        chk("j0_ready_lo", 512'(ap_ready), 512'(0));
        ap_start = 1'b0;
        tick();
        chk("j0_pulse_end", 512'({rmst_req, op_start}), 512'(0));
        chk("j0_ready_busy", 512'(ap_ready), 512'(0));
        rmst_done = 1'b1;
        tick();
        rmst_done = 1'b0;
        chk("j0_ready_back", 512'(ap_ready), 512'(1));
        chk("j0_idle", 512'(ap_idle), 512'(0));
        s_rd_tvalid = 1'b1;
        #1;
        chk("rd_vld1", 512'(eng_rd_tvalid), 512'(4'b0010));
        s_rd_tvalid = 1'b0;

        // fill engines 1..3, then the fifth job must stall
        do_job(1, "j1");
        do_job(2, "j2");
        do_job(3, "j3");
        ap_start = 1'b1;
        #1;
        chk("full_ready", 512'(ap_ready), 512'(0));
        tick();
        chk("full_no_req", 512'(rmst_req), 512'(0));
        ap_start = 1'b0;

        // out-of-order write request: engine 1 first must wait
        eng_wreq = 4'b0010;
        tick();
        eng_wreq = '0;
        tick(); tick();
        chk("ooo_wait", 512'(wmst_req), 512'(0));
        chk("ooo_addr0", 512'(wmst_xfer_addr), 512'(addr_of(0)));
        eng_wreq = 4'b0001;
        tick();
        eng_wreq = '0;
        chk("ooo_latch_only", 512'(wmst_req), 512'(0));
        tick();
        chk("ooo_req0", 512'(wmst_req), 512'(1));
        chk("ooo_req0_addr", 512'(wmst_xfer_addr), 512'(addr_of(0)));
        chk("ooo_req0_size", 512'(wmst_xfer_size), 512'(size_of(0)));
        tick();
        chk("ooo_req0_end", 512'(wmst_req), 512'(0));

        // write mux follows out_ptr=0
        eng_wr_tvalid = 4'b0011;
        eng_wr_tdata  = {256'd0, 128'h1111, 128'hBEEF};
        m_wr_tready   = 1'b1;
        #1;
        chk("wr_vld", 512'(m_wr_tvalid), 512'(1));
        chk("wr_dat", 512'(m_wr_tdata), 512'(128'hBEEF));
        chk("wr_rdy", 512'(eng_wr_tready), 512'(4'b0001));
        eng_wr_tvalid = '0; eng_wr_tdata = '0; m_wr_tready = 1'b0;

        // first completion frees an engine; engine 1 write issues next
        wmst_done = 1'b1;
        tick();
        wmst_done = 1'b0;
        chk("wd1_ready", 512'(ap_ready), 512'(1));
        chk("wd1_done", 512'(ap_done), 512'(1));
        chk("wd1_addr1", 512'(wmst_xfer_addr), 512'(addr_of(1)));
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        chk("j4_op_start", 512'(op_start), 512'(4'b0001));
        chk("j4_wmst_req1", 512'(wmst_req), 512'(1));
        chk("j4_addr1", 512'(wmst_xfer_addr), 512'(addr_of(1)));
        rmst_done = 1'b1;
        tick();
        rmst_done = 1'b0;
        chk("j4_full", 512'(ap_ready), 512'(0));
        wmst_done = 1'b1;
        tick();
        wmst_done = 1'b0;

        // accept and wmst_done in the same cycle: busy count holds at 3
        eng_wreq = 4'b0100;
        tick();
        eng_wreq = '0;
        tick();
        chk("w2_req", 512'(wmst_req), 512'(1));
        tick();
        ap_start = 1'b1;
        wmst_done = 1'b1;
        tick();
        ap_start = 1'b0;
        wmst_done = 1'b0;
        chk("simul_op_start", 512'(op_start), 512'(4'b0010));
        rmst_done = 1'b1;
        tick();
        rmst_done = 1'b0;
        chk("simul_busy_ready", 512'(ap_ready), 512'(1));

        // wmst_done together with ap_continue: pending count holds at 3
        eng_wreq = 4'b1000;
        tick();
        eng_wreq = '0;
        tick();
        chk("w3_req", 512'(wmst_req), 512'(1));
        tick();
        wmst_done = 1'b1;
        ap_continue = 1'b1;
        tick();
        wmst_done = 1'b0;
        chk("pend_c0", 512'(ap_done), 512'(1));
        tick();
        chk("pend_c1", 512'(ap_done), 512'(1));
        tick();
        chk("pend_c2", 512'(ap_done), 512'(1));
        tick();
        ap_continue = 1'b0;
        chk("pend_c3", 512'(ap_done), 512'(0));

        // drain the two remaining jobs (engines 0 and 1) and acknowledge
        do_write(0, "d0");
        do_write(1, "d1");
        chk("drain_not_idle", 512'(ap_idle), 512'(0));
        ap_continue = 1'b1;
        tick(); tick();
        ap_continue = 1'b0;
        chk("drain_idle", 512'(ap_idle), 512'(1));
        chk("drain_done", 512'(ap_done), 512'(0));

        // stray rmst_done while idle leaves in_ptr at 2
        rmst_done = 1'b1;
        tick();
        rmst_done = 1'b0;
        s_rd_tvalid = 1'b1;
        #1;
        chk("stray_rdone", 512'(eng_rd_tvalid), 512'(4'b0100));
        s_rd_tvalid = 1'b0;

        // reset while a write transfer is in flight
        do_job(2, "j6");
        eng_wreq = 4'b0100;
        tick();
        eng_wreq = '0;
        tick();
        chk("w6_req", 512'(wmst_req), 512'(1));
        tick();
        areset_n = 1'b0;
        tick();
        chk("mid_rst_ctrl", 512'({ap_ready, ap_idle, ap_done}), 512'(3'b110));
        chk("mid_rst_pulses", 512'({rmst_req, wmst_req, op_start}), 512'(0));
        chk("mid_rst_addr", 512'(wmst_xfer_addr), 512'(addr_of(0)));
        areset_n = 1'b1;
        tick();
        do_job(0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
